// File: rtl/wb_stage.sv
// Registered write-back stage: picks ALU / load / PC+4 / immediate results, aligns and extends
// sub-word loads, and waits on the memory response with an optional timeout.
module wb_stage #(
    parameter int XLEN    = 32,
    parameter int RA_W    = 5,
    parameter int TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      wb_sel,
    input  logic            reg_write,
    input  logic [RA_W-1:0] rd,
    input  logic [XLEN-1:0] alu_result,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] imm,
    input  logic [1:0]      load_size,
    input  logic            load_unsigned,
    input  logic [2:0]      byte_off,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            rf_we,
    output logic [RA_W-1:0] rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    output logic            busy,
    output logic            err
);

    localparam logic [1:0] SEL_ALU = 2'b00;
    localparam logic [1:0] SEL_MEM = 2'b01;
    localparam logic [1:0] SEL_PC4 = 2'b10;
    localparam logic [1:0] SEL_IMM = 2'b11;

    localparam logic [1:0] LS_BYTE = 2'b00;
    localparam logic [1:0] LS_HALF = 2'b01;
    localparam logic [1:0] LS_WORD = 2'b10;

    localparam int               CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [0:0] {
        IDLE,
        WAIT_MEM
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  wait_cnt;

    logic              reg_write_q;
    logic [RA_W-1:0]   rd_q;
    logic [1:0]        load_size_q;
    logic              load_unsigned_q;
    logic [2:0]        byte_off_q;

    logic              accept;
    logic [XLEN-1:0]   direct_result;
    logic [2:0]        off_eff;
    logic [XLEN-1:0]   shifted;
    logic              fill;
    logic [XLEN-1:0]   byte_ext;
    logic [XLEN-1:0]   half_ext;
    logic [XLEN-1:0]   word_ext;
    logic [XLEN-1:0]   load_data;

    assign in_ready = (state == IDLE) && !rst;
    assign accept   = in_valid && in_ready;

    always_comb begin
        direct_result = alu_result;
        case (wb_sel)
            SEL_PC4: direct_result = pc + XLEN'(4);
            SEL_IMM: direct_result = imm;
            default: direct_result = alu_result;
        endcase
    end

    // Misaligned offsets are rounded down to the access size; a 32-bit datapath has no byte_off[2].
    always_comb begin
        off_eff = byte_off_q;
        if (XLEN == 32) begin
            off_eff[2] = 1'b0;
        end
        case (load_size_q)
            LS_BYTE: off_eff = off_eff;
            LS_HALF: off_eff[0] = 1'b0;
            LS_WORD: off_eff[1:0] = 2'b00;
            default: off_eff = 3'b000;
        endcase
    end

    assign shifted = mem_rdata >> {off_eff, 3'b000};

    // Sign extension is done by OR-ing a fill mask above the field, which also works when the field is XLEN wide.
    always_comb begin
        fill = 1'b0;
        case (load_size_q)
            LS_BYTE: fill = !load_unsigned_q && shifted[7];
            LS_HALF: fill = !load_unsigned_q && shifted[15];
            default: fill = !load_unsigned_q && shifted[31];
        endcase
        byte_ext = XLEN'(shifted[7:0])  | ({XLEN{fill}} & ~XLEN'(8'hFF));
        half_ext = XLEN'(shifted[15:0]) | ({XLEN{fill}} & ~XLEN'(16'hFFFF));
        word_ext = XLEN'(shifted[31:0]) | ({XLEN{fill}} & ~XLEN'(32'hFFFF_FFFF));
        case (load_size_q)
            LS_BYTE: load_data = byte_ext;
            LS_HALF: load_data = half_ext;
            LS_WORD: load_data = word_ext;
            default: load_data = (XLEN == 64) ? shifted : word_ext;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            wait_cnt        <= '0;
            busy            <= 1'b0;
            err             <= 1'b0;
            rf_we           <= 1'b0;
            rf_waddr        <= '0;
            rf_wdata        <= '0;
            reg_write_q     <= 1'b0;
            rd_q            <= '0;
            load_size_q     <= 2'b00;
            load_unsigned_q <= 1'b0;
            byte_off_q      <= 3'b000;
        end else begin
            rf_we <= 1'b0;
            err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        reg_write_q     <= reg_write;
                        rd_q            <= rd;
                        load_size_q     <= load_size;
                        load_unsigned_q <= load_unsigned;
                        byte_off_q      <= byte_off;
                        if (wb_sel == SEL_MEM) begin
                            state    <= WAIT_MEM;
                            busy     <= 1'b1;
                            wait_cnt <= '0;
                        end else if (reg_write && (rd != '0)) begin
                            rf_we    <= 1'b1;
                            rf_waddr <= rd;
                            rf_wdata <= direct_result;
                        end
                    end
                end
                WAIT_MEM: begin
                    // A response arriving on the expiry cycle still wins over the timeout.
                    if (mem_rvalid) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        if (reg_write_q && (rd_q != '0)) begin
                            rf_we    <= 1'b1;
                            rf_waddr <= rd_q;
                            rf_wdata <= load_data;
                        end
                    end else if ((TIMEOUT != 0) && (wait_cnt == CNT_LAST)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        err   <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/wb_stage.md
# wb_stage

Parametrised, registered write-back stage for the CPU datapath. It supersedes the two-input ALU/memory write-back mux and selects among four result sources: ALU, load data, PC+4 and immediate. It also aligns and sign- or zero-extends sub-word loads, waits on a memory-response handshake with a timeout, and drives the register-file write port one cycle after completion.

## Interface
- XLEN, 32: datapath width; legal values 32 or 64.
- RA_W, 5: register address width.
- TIMEOUT, 16: maximum cycles to wait for `mem_rvalid`; 0 disables the timeout.

Ports:
- clk  in  1  clock; everything is updated on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  an instruction is presented for write-back.
- in_ready  out  1  stage can accept an instruction; combinational, 1 only in IDLE and not in reset.
- wb_sel  in  2  source select: 00 ALU, 01 MEM, 10 PC+4, 11 IMM.
- reg_write  in  1  instruction writes rd.
- rd  in  RA_W  destination register.
- alu_result, pc, imm  in  XLEN each  source operands.
- load_size  in  2  00 byte, 01 half, 10 word, 11 dword.
- load_unsigned  in  1  1 = zero-extend, 0 = sign-extend.
- byte_off  in  3  address low bits of the load.
- mem_rvalid  in  1  load data valid this cycle.
- mem_rdata  in  XLEN  raw aligned memory word.
- rf_we  out  1  register-file write strobe (single-cycle pulse).
- rf_waddr  out  RA_W  write address.
- rf_wdata  out  XLEN  write data.
- busy  out  1  high in WAIT_MEM.
- err  out  1  single-cycle pulse on load timeout.

## Operation
- FSM states: IDLE and WAIT_MEM. Reset forces IDLE and clears all outputs: rf_we, rf_waddr, rf_wdata, busy and err are all 0.
- Accept means `in_valid & in_ready`. On accept the stage latches wb_sel, reg_write, rd, load_size, load_unsigned and byte_off.
- Non-MEM accept: the stage stays in IDLE and registers the result. On the next cycle:
  - rf_we = reg_write & (rd != 0)
  - rf_waddr = rd
  - rf_wdata is the selected source.
- PC+4 is computed modulo 2^XLEN, so it wraps to 0 with no flag.
- MEM accept: the stage goes to WAIT_MEM, busy=1, in_ready=0, and the wait counter clears to 0.
- In WAIT_MEM on `mem_rvalid`: the stage extracts the load data, registers the write (same rf_we rule as above) and returns to IDLE.
- In WAIT_MEM without `mem_rvalid`: the counter increments. When the counter reaches TIMEOUT-1 with no `mem_rvalid` (TIMEOUT != 0), the next edge:
  - pulses err for one cycle,
  - performs no write,
  - returns to IDLE.
- `mem_rvalid` is ignored in IDLE, including on the accept cycle itself. A response must arrive at least one cycle after accept.
- Load extraction:
  - shifted = mem_rdata >> (8 × byte_off).
  - Byte: bits [7:0]. Half: bits [15:0]. Word: bits [31:0]. Dword: all 64 bits.
  - The result is extended to XLEN, using bit 7, 15 or 31 when load_unsigned=0.
- Misaligned offsets:
  - Half ignores byte_off[0].
  - Word ignores byte_off[1:0].
  - Dword ignores byte_off entirely.
- XLEN=32 differences:
  - byte_off[2] is ignored.
  - load_size 11 behaves as word.
  - Word loads are not extended.
- rf_wdata and rf_waddr hold their last value while rf_we=0.
- A reset asserted mid-WAIT_MEM abandons the load: no write, no err.

## Timing
- Non-MEM latency: accept on edge N, rf_we=1 during cycle N+1, one cycle wide. Throughput is one instruction per cycle.
- MEM latency: `mem_rvalid` sampled on edge M, rf_we=1 during cycle M+1. in_ready returns to 1 in cycle M+1, so back-to-back accept is allowed.
- Timeout: with TIMEOUT=T, a load accepted on edge N with no response has err=1 during cycle N+T+1. in_ready=1 in the same cycle.
- in_ready depends only on state and rst. There is no combinational path from in_valid to in_ready.
- Simultaneous `mem_rvalid` and timeout expiry: the data wins, so the write happens and err stays 0.

## Test plan
- Reset, then ALU op with alu_result=0x12345678, rd=5, wb_sel=00 → next cycle rf_we=1, rf_waddr=5, rf_wdata=0x12345678; rd=0 with the same data → rf_we stays 0.
- PC+4 with pc=0xFFFFFFFC (XLEN=32) → rf_wdata=0x00000000; IMM with imm=0xFFFFF800 → rf_wdata=0xFFFFF800.
- Byte load with mem_rdata=0x80FF7F01, byte_off=3, signed → 0xFFFFFF80; unsigned → 0x00000080; half load, byte_off=2, signed → 0xFFFF80FF.
- Load with mem_rvalid delayed 3 cycles: busy=1 and in_ready=0 for 3 cycles, then rf_we one cycle after mem_rvalid, then an immediately following ALU op is accepted.
- TIMEOUT=4, no mem_rvalid: err pulses exactly once, no rf_we, and the stage returns to IDLE. Repeat with rst asserted in the second WAIT_MEM cycle: no err, no rf_we, and all outputs are 0 the cycle after reset.
- XLEN=64: dword load with 0x8000000000000001 → rf_wdata unchanged; word load, byte_off=4, signed, upper word 0x80000000 → 0xFFFFFFFF80000000.
